uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 7, data bits per frame; legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 8, ena ticks per bit; power of 2, legal 4..16.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  oversample tick; the bit-timing FSM advances only in cycles where ena=1.
REQ-007 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-008 SHALL have port data_out  output  DATA_BITS  received word, LSB = first bit on the line.
REQ-009 SHALL have port valid_out  output  1  data_out, parity_err and frame_err hold a valid word.
REQ-010 SHALL have port ready_in  input  1  consumer accepts the word.
REQ-011 SHALL have port parity_err  output  1  parity mismatch for the held word; 0 when PARITY=0.
REQ-012 SHALL have port frame_err  output  1  stop bit sampled low for the held word.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port state_out  output  3  current FSM state, for debug.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer on clk, independent of ena; the FSM uses only the synchronized value (rxs).
REQ-016 SHALL implement states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5; all other encodings go to IDLE on the next ena tick.
REQ-017 IDLE: on an ena tick with rxs=0 -> START, with the tick counter cleared.
REQ-018 START: sample rxs on the tick where the counter reaches OVERSAMPLE/2-1; rxs=0 -> DATA, counter cleared; rxs=1 -> IDLE (false start, no output).
REQ-019 DATA: sample rxs every OVERSAMPLE ticks and shift it in LSB-first; after DATA_BITS samples -> PARITY if PARITY!=0, otherwise -> STOP.
REQ-020 PARITY: sample one bit; the error is (XOR of data bits XOR parity bit) for even mode and its inverse for odd mode.
REQ-021 STOP: sample one bit; rxs=0 sets frame error, rxs=1 clears it; then go to IDLE, or to BREAK if rxs=0 and all data bits are 0.
REQ-022 BREAK: remain until an ena tick with rxs=1, then -> IDLE; no further words are produced during BREAK.
REQ-023 SHALL complete a frame on the clk cycle after the stop-bit sample: load data_out, parity_err and frame_err, and set valid_out=1.
REQ-024 Handshake: transfer occurs on a cycle with valid_out=1 and ready_in=1; valid_out then deasserts on the next cycle.
REQ-025 While valid_out=1, data_out, parity_err and frame_err SHALL hold stable.
REQ-026 If a frame completes while valid_out=1 and ready_in=0, the new frame SHALL be dropped, the held word kept, and overrun pulsed high for 1 cycle.
REQ-027 If a frame completes in the same cycle as a transfer (valid_out=1, ready_in=1), the new word SHALL load and valid_out SHALL stay 1, with no overrun.
REQ-028 ena=0 SHALL freeze the FSM, counters and shift register; the handshake and synchronizer keep running.
REQ-029 Frames with frame_err=1 or parity_err=1 SHALL still be delivered, with the flag set.

Reset
REQ-030 On reset: state=IDLE, counters=0, shift register=0, data_out=0, valid_out=0, parity_err=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no valid_out; after release, reception restarts at the next falling edge.

Structure
REQ-032 Package uart_pkg SHALL hold the state encodings and the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-033 SHALL instantiate one sub-module, uart_sync2 (2-flop synchronizer, reset value 1); all other logic is in uart_rx_cfg.

Verification (DATA_BITS=7, OVERSAMPLE=8, ena=1 every cycle unless stated)
REQ-034 Frame 0x5A, PARITY=0, ready_in=1 -> data_out=0x5A, valid_out high for 1 cycle, errors=0.
REQ-035 PARITY=1, frame 0x13 with parity bit 0 (wrong) -> data_out=0x13, parity_err=1; the same frame with PARITY=2 -> parity_err=0.
REQ-036 Two frames 0x11 then 0x22 with ready_in=0 -> data_out stays 0x11, overrun pulses once on completion of 0x22.
REQ-037 rx low for 2 cycles then high -> no START->DATA transition, valid_out stays 0; a 12-bit-time low -> one word 0x00 with frame_err=1, FSM in BREAK until rx=1.
REQ-038 ena=1 only every 3rd cycle, frame 0x7F -> correct word delivered; rst_n pulsed low during bit 3 -> no valid_out, and the next frame 0x01 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encodings and parity-mode constants for the UART RX.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM state encoding (also exported on state_out for debug)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchronizer for the asynchronous serial line.
//            Both flops reset to 1 so a reset never looks like a start bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resynchronisation, idle-high reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Configurable UART receiver with oversampled bit timing,
//            optional parity, frame/break detection and a valid/ready
//            output holding register with overrun indication.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 7,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           state_out
);

  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic             HAS_PAR  = (PARITY != PAR_NONE);
  localparam logic             ODD_INV  = (PARITY == PAR_ODD);

  logic                 rxs;
  state_t               state;
  logic [CNT_W-1:0]     tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic                 done;
  logic                 at_full;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  assign at_full   = (tick_cnt == CNT_FULL);
  assign state_out = state;

  // Bit-timing FSM: advances only on ena ticks; done is a one-clk pulse
  // raised on the stop-bit sample so the word is published next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ena) begin
        case (state)
          ST_IDLE: begin
            if (!rxs) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == CNT_HALF) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              // A line that is high again mid-start-bit is a glitch
              state    <= rxs ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + CNT_ONE;
            end
          end
          ST_DATA: begin
            if (at_full) begin
              tick_cnt <= '0;
              shift    <= {rxs, shift[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= HAS_PAR ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_ONE;
            end
          end
          ST_PARITY: begin
            if (at_full) begin
              tick_cnt  <= '0;
              par_err_q <= (^shift) ^ rxs ^ ODD_INV;
              state     <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + CNT_ONE;
            end
          end
          ST_STOP: begin
            if (at_full) begin
              tick_cnt  <= '0;
              frm_err_q <= ~rxs;
              done      <= 1'b1;
              // Low stop bit on an all-zero word means a line break
              state     <= (!rxs && (shift == '0)) ? ST_BREAK : ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + CNT_ONE;
            end
          end
          ST_BREAK: begin
            if (rxs) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
      if (done) begin
        // Load when empty or when the held word leaves this same cycle
        if (!valid_out || ready_in) begin
          data_out   <= shift;
          parity_err <= HAS_PAR & par_err_q;
          frame_err  <= frm_err_q;
          valid_out  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule : uart_rx_cfg
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Scoreboard bench for uart_rx_cfg: one PARITY=0 instance plus
//            even/odd parity instances sharing a second serial line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

  localparam int DB = 7;
  localparam int OS = 8;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } word_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic ena      = 1'b1;
  logic ena_slow = 1'b0;
  int   ena_ph   = 0;
  logic rx0      = 1'b1;
  logic rx_p     = 1'b1;
  logic ready0   = 1'b1;

  logic [DB-1:0] data0, data1, data2;
  logic          v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;
  logic [2:0]    st0, st1, st2;

  word_t q0[$];
  word_t q1[$];
  word_t q2[$];

  int    vectors     = 0;
  int    miscompares = 0;
  int    ovr_seen    = 0;
  logic  prev_stall  = 1'b0;
  word_t prev_w      = '0;

  uart_rx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx0), .data_out(data0),
    .valid_out(v0), .ready_in(ready0), .parity_err(pe0), .frame_err(fe0),
    .overrun(ov0), .state_out(st0));

  uart_rx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx_p), .data_out(data1),
    .valid_out(v1), .ready_in(1'b1), .parity_err(pe1), .frame_err(fe1),
    .overrun(ov1), .state_out(st1));

  uart_rx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx_p), .data_out(data2),
    .valid_out(v2), .ready_in(1'b1), .parity_err(pe2), .frame_err(fe2),
    .overrun(ov2), .state_out(st2));

  always #5 clk = ~clk;

  // Oversample tick: every cycle, or every third cycle in slow mode
  always @(negedge clk) begin
    ena_ph = (ena_ph == 2) ? 0 : ena_ph + 1;
    ena    = ena_slow ? (ena_ph == 0) : 1'b1;
  end

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor for the main instance: words, overrun pulses, hold stability
  always @(negedge clk) begin
    if (v0 && ready0) begin
      if (q0.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL d0_word: got unexpected word %0h, required none", data0);
      end else begin
        cmp("d0_word", {data0, pe0, fe0}, q0.pop_front());
      end
    end
    if (ov0) ovr_seen++;
    if (prev_stall && v0) cmp("d0_hold", {data0, pe0, fe0}, prev_w);
    prev_stall = v0 && !ready0;
    prev_w     = {data0, pe0, fe0};
  end

  // Monitor for the even-parity instance
  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL d1_word: got unexpected word %0h, required none", data1);
      end else begin
        cmp("d1_even_word", {data1, pe1, fe1}, q1.pop_front());
      end
    end
  end

  // Monitor for the odd-parity instance
  always @(negedge clk) begin
    if (v2) begin
      if (q2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL d2_word: got unexpected word %0h, required none", data2);
      end else begin
        cmp("d2_odd_word", {data2, pe2, fe2}, q2.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic val, input int n);
    if (sel == 0) rx0 = val;
    else          rx_p = val;
    wait_cyc(n);
  endtask

  task automatic send(input int sel, input logic [DB-1:0] d, input bit use_par,
                      input logic pbit, input logic stop);
    int bt = OS * (ena_slow ? 3 : 1);
    drive(sel, 1'b0, bt);
    for (int i = 0; i < DB; i++) drive(sel, d[i], bt);
    if (use_par) drive(sel, pbit, bt);
    drive(sel, stop, bt);
    drive(sel, 1'b1, 2 * bt);
  endtask

  task automatic set_ready0(input logic val);
    @(posedge clk);
    #1 ready0 = val;
  endtask

  // Bounded run time
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus with expected words pushed to the scoreboards
  initial begin
    logic saw_start;
    logic saw_data;

    wait_cyc(4);
    cmp("rst_data", data0, 0);
    cmp("rst_valid", v0, 0);
    cmp("rst_flags", {pe0, fe0, ov0}, 0);
    cmp("rst_state", st0, 0);
    cmp("rst_valid_par", {v1, v2}, 0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Plain frame, consumer always ready
    q0.push_back({7'h5A, 1'b0, 1'b0});
    send(0, 7'h5A, 0, 1'b0, 1'b1);
    cmp("5a_valid_low", v0, 0);

    // Parity: 0x13 has three ones
    q1.push_back({7'h13, 1'b1, 1'b0}); q2.push_back({7'h13, 1'b0, 1'b0});
    send(1, 7'h13, 1, 1'b0, 1'b1);
    q1.push_back({7'h13, 1'b0, 1'b0}); q2.push_back({7'h13, 1'b1, 1'b0});
    send(1, 7'h13, 1, 1'b1, 1'b1);
    // 0x55 has four ones
    q1.push_back({7'h55, 1'b0, 1'b0}); q2.push_back({7'h55, 1'b1, 1'b0});
    send(1, 7'h55, 1, 1'b0, 1'b1);
    // 0x2C has three ones, stop bit low, non-zero data so no break
    q1.push_back({7'h2C, 1'b0, 1'b1}); q2.push_back({7'h2C, 1'b1, 1'b1});
    send(1, 7'h2C, 1, 1'b1, 1'b0);
    cmp("par_idle", {st1, st2}, 0);

    // Overrun: second frame dropped while first is held
    set_ready0(1'b0);
    q0.push_back({7'h11, 1'b0, 1'b0});
    send(0, 7'h11, 0, 1'b0, 1'b1);
    cmp("ovr_first_held", {v0, data0}, {1'b1, 7'h11});
    send(0, 7'h22, 0, 1'b0, 1'b1);
    cmp("ovr_pulses", ovr_seen, 1);
    cmp("ovr_still_11", {v0, data0}, {1'b1, 7'h11});
    set_ready0(1'b1);
    wait_cyc(4);
    cmp("ovr_released", v0, 0);

    // False start: two-cycle glitch
    saw_start = 1'b0;
    saw_data  = 1'b0;
    drive(0, 1'b0, 2);
    rx0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (st0 == 3'd1) saw_start = 1'b1;
      if (st0 == 3'd2) saw_data  = 1'b1;
    end
    cmp("fs_started", saw_start, 1);
    cmp("fs_no_data", saw_data, 0);
    cmp("fs_idle", st0, 0);

    // Break: 12 bit times low
    q0.push_back({7'h00, 1'b0, 1'b1});
    drive(0, 1'b0, 12 * OS);
    cmp("brk_state", st0, 5);
    drive(0, 1'b1, OS);
    cmp("brk_exit", st0, 0);
    wait_cyc(2 * OS);

    // Slow oversample tick
    ena_slow = 1'b1;
    wait_cyc(6);
    q0.push_back({7'h7F, 1'b0, 1'b0});
    send(0, 7'h7F, 0, 1'b0, 1'b1);
    cmp("slow_data", data0, 7'h7F);

    // Reset during bit 3 of 0x78: no falling edges after bit 2
    drive(0, 1'b0, 3 * OS);      // start bit
    drive(0, 1'b0, 3 * 3 * OS);  // bits 0..2
    drive(0, 1'b1, 8);           // into bit 3
    rst_n = 1'b0;
    wait_cyc(1);
    cmp("midrst_state", st0, 0);
    cmp("midrst_valid", v0, 0);
    cmp("midrst_data", data0, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    drive(0, 1'b1, 6 * 3 * OS);
    cmp("midrst_no_word", v0, 0);
    q0.push_back({7'h01, 1'b0, 1'b0});
    send(0, 7'h01, 0, 1'b0, 1'b1);
    ena_slow = 1'b0;

    wait_cyc(20);
    cmp("q0_drained", q0.size(), 0);
    cmp("q1_drained", q1.size(), 0);
    cmp("q2_drained", q2.size(), 0);
    cmp("ovr_total", ovr_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx_cfg
`default_nettype wire
